shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-step shift/rotate controller wrapped around the single-step shift unit `unidad_corrimiento_3a`.
- Accepts a command of {op, amount, data} over a valid/ready handshake.
- Drives the unit once per cycle on a registered operand until `amt` steps are done, then presents the result over a valid/ready output handshake.
- Sits between the ALU control path and the shift datapath; one command in flight at a time.

Parameters:
- N, 4, operand width in bits; must be a power of two, enforced by an elaboration-time assertion.
- AW, 3, width of the shift amount field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  sequencer can accept a command.
- op  input  3  operation code: 001 shl, 010 shr, 011 clear, 101 rol, 111 ror, any other value transfer.
- amt  input  AW  requested number of single-bit steps.
- data  input  N  signed operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  N  signed final value.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: asynchronous, active-low on rst_n; one clock, clk. While rst_n=0 and after release:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - result=0, internal operand register=0, counter=0
- States: IDLE, RUN, DONE. Accept happens when in_valid && in_ready; in_ready=1 only in IDLE.
- On accept, op is latched into op_r and the effective count eff is computed:
  - shl/shr: eff = min(amt, N). Any amt >= N yields all zeros after N steps.
  - rol/ror: eff = amt mod N, i.e. the low log2(N) bits of amt.
  - clear/transfer: eff = 0.
- Accept cycle actions:
  - operand register <= data, except clear, which loads 0.
  - counter <= eff.
  - Next state is RUN if eff>0, else DONE.
- RUN, each cycle:
  - operand register <= unit output S with F=operand register, H=op_r.
  - counter decrements.
  - When counter==1 at the edge, next state is DONE.
- Shift semantics are the unit's, per step:
  - shl: logical left, zero fill.
  - shr: logical right, zero fill, no sign extension.
  - rol/ror: rotate by 1.
- Latency: out_valid rises exactly 1+eff cycles after the accept edge.
- DONE:
  - out_valid=1; result equals the operand register and holds stable while out_ready=0.
  - On out_valid && out_ready, next state is IDLE and out_valid drops the following cycle.
  - A new command can be accepted no earlier than the cycle after the result handshake; there is no overlap.
- Signals during IDLE:
  - in_valid during RUN/DONE is ignored; the source must hold it.
  - out_ready is don't-care outside DONE.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The in-flight command is dropped and no out_valid is produced.
- op/amt/data changing after accept has no effect; everything is taken from the latched copies.
- busy = (state != IDLE).

Decomposition:
- Package shift_pkg holds:
  - op encoding localparams (OP_SHL=3'b001, OP_SHR=3'b010, OP_CLR=3'b011, OP_ROL=3'b101, OP_ROR=3'b111).
  - state enum (IDLE, RUN, DONE).
  - helper function eff_count(op, amt, N).
- One sub-module instance: unidad_corrimiento_3a #(.N(N)), combinational, fed from the operand register and op_r.
- Everything else (FSM, counter, registers) is flat in shift_sequencer.

Test Plan:
- N=4, shl, amt=3, data=0001, out_ready=1 -> out_valid at accept+4, result=1000, in_ready back high the cycle after the handshake.
- rol, amt=1, data=1001 -> result=0011 at accept+2. ror, amt=5 (eff=1), data=1001 -> result=1100 at accept+2.
- shr, amt=7, data=1111 -> clamped to 4 steps, result=0000 at accept+5; confirms no sign extension (after step 1 the value is 0111).
- clear, amt=6, data=1010 -> result=0000 at accept+1. op=000 (transfer), data=0110 -> result=0110 at accept+1.
- Backpressure: shl amt=1, data=0011, out_ready=0 for 5 cycles -> out_valid held and result=0110 stable. A second in_valid in that window gets in_ready=0 and is not accepted until after the handshake.
- Reset mid-operation: rol amt=3 accepted, rst_n low on RUN cycle 2 -> all outputs at reset values the same cycle. After release, no out_valid and in_ready=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-step shift sequencer: op codes, FSM states
// and the effective step count rule.
package shift_pkg;

  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_CLR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shifts saturate at n steps (everything is shifted out by then); rotates
  // wrap modulo n, which is a mask because n is a power of two.
  function automatic int unsigned eff_count(input logic [2:0] op,
                                            input int unsigned amt,
                                            input int unsigned n);
    case (op)
      OP_SHL, OP_SHR: return (amt < n) ? amt : n;
      OP_ROL, OP_ROR: return amt & (n - 1);
      default:        return 0;
    endcase
  endfunction

endpackage

// File: rtl/unidad_corrimiento_3a.sv
// Single-step combinational shift/rotate unit: one bit of movement per use.
module unidad_corrimiento_3a
  import shift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] F,
  input  logic [2:0]   H,
  output logic [N-1:0] S
);

  always_comb begin
    case (H)
      OP_SHL:  S = {F[N-2:0], 1'b0};
      OP_SHR:  S = {1'b0, F[N-1:1]};
      OP_CLR:  S = '0;
      OP_ROL:  S = {F[N-2:0], F[N-1]};
      OP_ROR:  S = {F[0], F[N-1:1]};
      default: S = F;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate controller: latches a command, iterates the
// single-step unit eff times, then holds the result until it is taken.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic          busy
);

  // Counter must be able to hold N itself (saturated shift count).
  localparam int CW = $clog2(N + 1);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_n_check
    $error("shift_sequencer: N must be a power of two >= 2");
  end

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  eff_w;
  logic [N-1:0]   unit_s;

  assign eff_w = CW'(eff_count(op, 32'(amt), N));

  unidad_corrimiento_3a #(.N(N)) u_unit (
    .F (opnd_q),
    .H (op_q),
    .S (unit_s)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          opnd_d  = (op == OP_CLR) ? '0 : data;
          cnt_d   = eff_w;
          state_d = (eff_w != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        opnd_d = unit_s;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = opnd_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an arithmetic
// reference model of the shift/rotate rules.
module tb_shift_sequencer;

  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'b000;
  logic [AW-1:0] amt = '0;
  logic [N-1:0]  data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  result;
  logic          busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .amt       (amt),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: steps and final value from the operation rules.
  function automatic int ref_eff(input int o, input int a);
    case (o)
      1, 2:    return (a < N) ? a : N;
      5, 7:    return a % N;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_res(input int o, input int a, input int d);
    int mask = (1 << N) - 1;
    int e = ref_eff(o, a);
    case (o)
      1:       return (d << e) & mask;
      2:       return d >> e;
      3:       return 0;
      5:       return ((d << e) | (d >> (N - e))) & mask;
      7:       return ((d >> e) | (d << (N - e))) & mask;
      default: return d;
    endcase
  endfunction

  task automatic do_cmd(input int o, input int a, input int d, input int hold);
    int w;
    int lat;
    int exp_r;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    check("ready_before_cmd", int'(in_ready), 1);
    in_valid  = 1'b1;
    op        = 3'(o);
    amt       = AW'(a);
    data      = N'(d);
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    op       = 3'($urandom);
    amt      = AW'($urandom);
    data     = N'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    exp_r = ref_res(o, a, d);
    check($sformatf("latency op=%0d amt=%0d", o, a), lat, 1 + ref_eff(o, a));
    check($sformatf("result op=%0d amt=%0d data=%0d", o, a, d), int'(result), exp_r);
    for (int k = 0; k < hold; k++) begin
      step();
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_result", int'(result), exp_r);
    end
    out_ready = 1'b1;
    step();
    check("post_hs_out_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
    $display("cmd op=%0d amt=%0d data=%0h -> result=%0h latency=%0d hold=%0d",
             o, a, d, exp_r, lat, hold);
  endtask

  initial begin
    // Reset state while rst_n is held low.
    #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result), 0);
    step();
    rst_n = 1'b1;
    step();
    check("after_rst_in_ready", int'(in_ready), 1);

    // Directed cases.
    do_cmd(1, 3, 4'b0001, 0);
    check("shl_result_1000", int'(result), 4'b1000);
    do_cmd(5, 1, 4'b1001, 0);
    do_cmd(7, 5, 4'b1001, 0);
    do_cmd(2, 7, 4'b1111, 0);
    do_cmd(2, 1, 4'b1111, 0);
    check("shr_no_sign_ext", int'(result), 4'b0111);
    do_cmd(3, 6, 4'b1010, 0);
    do_cmd(0, 2, 4'b0110, 0);
    do_cmd(1, 4, 4'b1111, 1);

    // Backpressure with a second command pending during DONE.
    in_valid = 1'b1; op = 3'b001; amt = 3'd1; data = 4'b0011; out_ready = 1'b0;
    step();
    op = 3'b101; amt = 3'd1; data = 4'b1001;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp2_out_valid", int'(out_valid), 1);
      check("bp2_result", int'(result), 4'b0110);
      check("bp2_in_ready", int'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    check("bp2_last_valid", int'(out_valid), 1);
    step();
    check("bp2_hs_out_valid", int'(out_valid), 0);
    check("bp2_hs_in_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("bp2_second_busy", int'(busy), 1);
    check("bp2_second_in_ready", int'(in_ready), 0);
    step();
    check("bp2_second_valid", int'(out_valid), 1);
    check("bp2_second_result", int'(result), 4'b0011);
    step();
    check("bp2_second_done", int'(in_ready), 1);
    $display("backpressure sequence complete");

    // Reset in the middle of a rotate.
    in_valid = 1'b1; op = 3'b101; amt = 3'd3; data = 4'b0110;
    step();
    in_valid = 1'b0;
    step();
    check("mid_run_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_result", int'(result), 0);
    step();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("postrst_no_valid", int'(out_valid), 0);
      check("postrst_in_ready", int'(in_ready), 1);
    end
    $display("mid-run reset sequence complete");

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
